// File: rtl/gcd_pkg.sv
// Shared definitions for the subtractive-GCD block: default widths, watchdog
// limit and the controller state encoding used by controller, datapath and bench.
package gcd_pkg;

    localparam int unsigned GCD_N        = 8;
    localparam int unsigned GCD_MAX_ITER = 2 ** GCD_N;

    // Encoding is fixed so waveforms and the legacy datapath bench decode it directly.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        ITER = 2'b10,
        DONE = 2'b11
    } gcd_state_t;

    // Busy covers operand load plus the subtract loop; DONE is already "not busy".
    function automatic logic state_busy(input gcd_state_t s);
        return (s == LOAD) || (s == ITER);
    endfunction

endpackage

// File: rtl/gcd_iter_counter.sv
// Subtract-cycle counter: synchronous clear, count enable, saturates at MAX
// and flags the terminal count so the controller can trip its watchdog.
module gcd_iter_counter
    import gcd_pkg::*;
#(
    parameter int unsigned W   = GCD_N + 1,
    parameter int unsigned MAX = GCD_MAX_ITER
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] MAX_CNT = W'(MAX);

    assign tc = (cnt == MAX_CNT);

    // Count enabled subtract cycles; hold at MAX instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/gcd_controller.sv
// Control FSM for the subtractive-GCD datapath: loads operands, steers one
// subtract per cycle from eq/gth, captures the result into R and pulses done.
// Adds start/busy/done handshake, abort, an iteration counter and a watchdog.
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int unsigned N        = GCD_N,
    parameter int unsigned MAX_ITER = 2 ** N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         eq,
    input  logic         gth,
    output logic         Selp,
    output logic         Selq,
    output logic         Sela,
    output logic         Selb,
    output logic         Ldp,
    output logic         Ldq,
    output logic         Ldr,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [N:0]   iter_cnt
);

    gcd_state_t state;
    gcd_state_t state_nxt;
    logic       accept;
    logic       cnt_en;
    logic       cnt_tc;
    logic       wd_fire;

    // abort in IDLE drops a simultaneous start.
    assign accept = (state == IDLE) && start && !abort;
    assign busy   = state_busy(state);

    gcd_iter_counter #(
        .W   (N + 1),
        .MAX (MAX_ITER)
    ) u_iter_counter (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (cnt_en),
        .cnt (iter_cnt),
        .tc  (cnt_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sticky watchdog flag, cleared only when a new run is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= 1'b0;
        end else if (wd_fire) begin
            err <= 1'b1;
        end
    end

    // Next-state and datapath control decode; abort forces IDLE with no loads.
    always_comb begin
        state_nxt = state;
        Selp      = 1'b0;
        Selq      = 1'b0;
        Sela      = 1'b0;
        Selb      = 1'b0;
        Ldp       = 1'b0;
        Ldq       = 1'b0;
        Ldr       = 1'b0;
        done      = 1'b0;
        cnt_en    = 1'b0;
        wd_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    Selp      = 1'b1;
                    Selq      = 1'b1;
                    Ldp       = 1'b1;
                    Ldq       = 1'b1;
                    state_nxt = ITER;
                end
            end
            ITER: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (eq) begin
                    Ldr       = 1'b1;
                    state_nxt = DONE;
                end else if (cnt_tc) begin
                    // Watchdog outranks another subtract once the budget is spent.
                    wd_fire   = 1'b1;
                    state_nxt = IDLE;
                end else if (gth) begin
                    Sela   = 1'b1;
                    Selb   = 1'b1;
                    Ldp    = 1'b1;
                    cnt_en = 1'b1;
                end else begin
                    Ldq    = 1'b1;
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                done      = !abort;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: a behavioural P/Q/R datapath closes the loop,
// a reference GCD model feeds a scoreboard that is checked at done/err.
module tb_gcd_controller;

    localparam int MAXI = 256;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       eq, gth;
    logic       Selp, Selq, Sela, Selb, Ldp, Ldq, Ldr, busy, done, err;
    logic [8:0] iter_cnt;

    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic [7:0] P, Q, R, alu;

    typedef struct {
        logic [7:0] r;
        int         cnt;
        bit         err;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    gcd_controller #(
        .N        (8),
        .MAX_ITER (MAXI)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .eq       (eq),
        .gth      (gth),
        .Selp     (Selp),
        .Selq     (Selq),
        .Sela     (Sela),
        .Selb     (Selb),
        .Ldp      (Ldp),
        .Ldq      (Ldq),
        .Ldr      (Ldr),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .iter_cnt (iter_cnt)
    );

    // Behavioural datapath driven by the controller's selects and loads.
    assign alu = (Sela ? P : Q) - (Selb ? Q : P);
    assign eq  = (P == Q);
    assign gth = (P > Q);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            P <= '0;
            Q <= '0;
            R <= '0;
        end else begin
            if (Ldp) P <= Selp ? a_in : alu;
            if (Ldq) Q <= Selq ? b_in : alu;
            if (Ldr) R <= P;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // Reference: subtractive GCD with the watchdog budget.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int p, q, k;
        p = int'(a);
        q = int'(b);
        k = 0;
        while (p != q && k < MAXI) begin
            if (p > q) p = p - q;
            else       q = q - p;
            k++;
        end
        e.err = (p != q);
        e.r   = 8'(p);
        e.cnt = k;
        e.lat = k + 3;
        return e;
    endfunction

    // One run: cyc counts cycles after the edge that sampled start (cyc 1 = LOAD).
    task automatic run_gcd(input logic [7:0] a, input logic [7:0] b, input bit hold);
        exp_t e, g;
        int   cyc, ldr_cyc, loads;
        bit   finished;
        e = model(a, b);
        sb.push_back(e);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        cyc = 1;
        if (!hold) start = 1'b0;
        check("load_ctl", 32'({busy, Selp, Selq, Ldp, Ldq, Ldr}), 32'b111110);
        finished = 1'b0;
        ldr_cyc  = -1;
        loads    = 0;
        while (!finished && cyc < 600) begin
            if (cyc > 1) loads += int'(Ldp) + int'(Ldq);
            if (Ldr && ldr_cyc < 0) ldr_cyc = cyc;
            if (done) begin
                start    = 1'b0;
                finished = 1'b1;
                g = sb.pop_front();
                check("end_is_done", 32'(1), 32'(!g.err));
                check("result_r", 32'(R), 32'(g.r));
                check("iter_cnt", 32'(iter_cnt), 32'(g.cnt));
                check("done_lat", 32'(cyc), 32'(g.lat));
                check("ldr_lat", 32'(ldr_cyc), 32'(g.lat - 1));
                check("sub_loads", 32'(loads), 32'(g.cnt));
                check("err_clr", 32'(err), 32'(0));
            end else if (!busy && cyc > 1) begin
                start    = 1'b0;
                finished = 1'b1;
                g = sb.pop_front();
                check("end_is_err", 32'(1), 32'(g.err));
                check("err_flag", 32'(err), 32'(1));
                check("wd_cnt", 32'(iter_cnt), 32'(g.cnt));
                check("wd_lat", 32'(cyc), 32'(g.lat));
                check("wd_no_ldr", 32'(ldr_cyc), 32'(-1));
                check("wd_loads", 32'(loads), 32'(g.cnt));
            end
            if (!finished) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!finished) begin
            check("run_timeout", 32'(0), 32'(1));
            void'(sb.pop_front());
            start = 1'b0;
        end
        @(negedge clk);
        check("post_done", 32'({done, busy}), 32'(0));
        @(negedge clk);
        check("post_idle", 32'({done, busy}), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [7:0] ra, rb;
        bit         seen;

        // Reset state
        #12;
        check("rst_ctl", 32'({Selp, Selq, Sela, Selb, Ldp, Ldq, Ldr, busy, done, err}), 32'(0));
        check("rst_cnt", 32'(iter_cnt), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_ctl", 32'({busy, done, err}), 32'(0));

        // Directed GCD runs
        run_gcd(8'd12, 8'd8, 1'b0);
        run_gcd(8'd255, 8'd1, 1'b0);
        run_gcd(8'd0, 8'd0, 1'b0);

        // Zero operand trips the watchdog
        run_gcd(8'd0, 8'd5, 1'b0);

        // abort with start in IDLE: start dropped, err left alone
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_idle", 32'(busy), 32'(0));
        check("err_sticky", 32'(err), 32'(1));
        check("cnt_held", 32'(iter_cnt), 32'(MAXI));

        // Equal operands, start held through the run: exactly one run
        run_gcd(8'd7, 8'd7, 1'b1);

        // abort mid-ITER
        @(negedge clk);
        a_in  = 8'd200;
        b_in  = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        #1;
        check("abort_loads", 32'({Ldp, Ldq, Ldr, done}), 32'(0));
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", 32'({busy, done, err}), 32'(0));
        check("abort_cnt", 32'(iter_cnt), 32'(8));
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= done | Ldr | busy;
        end
        check("abort_quiet", 32'(seen), 32'(0));
        run_gcd(8'd200, 8'd3, 1'b0);

        // Async reset mid-ITER
        @(negedge clk);
        a_in  = 8'd200;
        b_in  = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_ctl", 32'({Selp, Selq, Sela, Selb, Ldp, Ldq, Ldr, busy, done, err}), 32'(0));
        check("arst_cnt", 32'(iter_cnt), 32'(0));
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= done | busy;
        end
        check("arst_quiet", 32'(seen), 32'(0));

        // Random operand pairs
        for (int i = 0; i < 5; i++) begin
            ra = 8'($urandom_range(1, 255));
            rb = 8'($urandom_range(1, 255));
            run_gcd(ra, rb, 1'b0);
        end

        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
